int_ctrl: RTL and testbench

//  Interrupt source for the pipeline's fetch stage. Drives Int, Iaddr and EPC into IF and consumes ERET from decode.

---
 rtl/int_pkg.sv | 20 ++
 rtl/int_prio_enc.sv | 23 ++
 rtl/int_ctrl.sv | 146 ++++++++++++++
 tb/tb_int_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt controller.
package int_pkg;

  localparam int          N_IRQ_DEF      = 3;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0200;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0040;

  // Level / depth width for the default line count; a top built with a
  // different N_IRQ must keep this width in step.
  localparam int LVL_W = $clog2(N_IRQ_DEF + 1);

  typedef logic [LVL_W-1:0] lvl_t;

  // One nesting frame: where to return to and which level was interrupted.
  typedef struct packed {
    logic [31:0] pc;
    lvl_t        lvl;
  } stack_ent_t;

endpackage

// File: rtl/int_prio_enc.sv
// Highest-set-bit encoder: idx is the highest asserted request, valid if any.
module int_prio_enc #(
  parameter int W  = 3,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan upwards so the last hit, i.e. the highest index, wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Nesting fixed-priority interrupt controller feeding the IF stage.
// Requests are synchronised, edge-latched into pending, masked and granted
// above the current service level; return PCs live on an internal stack.
import int_pkg::*;

module int_ctrl #(
  parameter int          N_IRQ      = N_IRQ_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                         clk,
  input  logic                         CLR,
  input  logic [N_IRQ-1:0]             irq,
  input  logic                         mask_we,
  input  logic [N_IRQ-1:0]             mask_wdata,
  input  logic [31:0]                  PC_cur,
  input  logic                         PC_EN,
  input  logic                         Branch,
  input  logic                         J,
  input  logic                         ERET,
  output logic                         Int,
  output logic [31:0]                  Iaddr,
  output logic [31:0]                  EPC,
  output logic [N_IRQ-1:0]             pending,
  output logic [N_IRQ-1:0]             in_service,
  output logic [$clog2(N_IRQ+1)-1:0]   depth
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int LW = $clog2(N_IRQ + 1);

  logic [N_IRQ-1:0] s1, s2, s3;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] cand_oh;
  logic [N_IRQ-1:0] ret_clr;
  logic [IW-1:0]    srv_idx, cand_idx;
  logic             srv_valid, cand_valid;
  logic [LW-1:0]    lvl;
  logic             grant, ret;
  stack_ent_t       stack [N_IRQ];
  stack_ent_t       top_ent;

  // Current service level: highest in-service line + 1, 0 when idle.
  int_prio_enc #(.W(N_IRQ), .IW(IW)) u_srv_enc (
    .req   (in_service),
    .idx   (srv_idx),
    .valid (srv_valid)
  );

  assign lvl = srv_valid ? (LW'(srv_idx) + LW'(1)) : '0;

  // A line is eligible when pending, unmasked and strictly above the level.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      elig[i] = pending[i] & mask[i] & ((i + 1) > int'(lvl));
    end
  end

  int_prio_enc #(.W(N_IRQ), .IW(IW)) u_cand_enc (
    .req   (elig),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  // Never grant alongside a redirect or ERET: IF would drop the vector.
  // The depth test is a guard only; the level rule already bounds nesting.
  assign grant   = cand_valid & PC_EN & ~Branch & ~J & ~ERET & (int'(depth) < N_IRQ);
  assign ret     = ERET & PC_EN & (depth != '0);
  assign cand_oh = N_IRQ'(1) << cand_idx;
  assign rise    = s2 & ~s3;

  assign Int   = grant;
  assign Iaddr = grant ? (VEC_BASE + 32'(cand_idx) * VEC_STRIDE) : 32'h0;
  assign EPC   = top_ent.pc;

  // Select the top-of-stack frame; an empty stack reads as zero.
  always_comb begin
    top_ent = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (int'(depth) == i + 1) top_ent = stack[i];
    end
  end

  // On return, drop every in-service bit at or above the level being restored.
  always_comb begin
    ret_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (i >= int'(top_ent.lvl)) ret_clr[i] = 1'b1;
    end
  end

  // Three-flop synchroniser per line; rise marks the first high sample.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Mask register, all lines enabled out of reset.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR)          mask <= '1;
    else if (mask_we) mask <= mask_wdata;
  end

  // Pending / in-service / depth bookkeeping; a new edge beats the grant clear.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      pending    <= '0;
      in_service <= '0;
      depth      <= '0;
    end else begin
      if (grant) begin
        pending    <= (pending & ~cand_oh) | rise;
        in_service <= in_service | cand_oh;
        depth      <= depth + LW'(1);
      end else begin
        pending <= pending | rise;
        if (ret) begin
          in_service <= in_service & ~ret_clr;
          depth      <= depth - LW'(1);
        end
      end
    end
  end

  // Push the squashed PC and interrupted level into the next free frame.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < N_IRQ; i++) stack[i] <= '0;
    end else if (grant) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (int'(depth) == i) stack[i] <= '{pc: PC_cur, lvl: lvl_t'(lvl)};
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

  logic        clk;
  logic        CLR;
  logic [2:0]  irq;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic [31:0] PC_cur;
  logic        PC_EN;
  logic        Branch;
  logic        J;
  logic        ERET;
  logic        Int;
  logic [31:0] Iaddr;
  logic [31:0] EPC;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [1:0]  depth;

  int n_chk;
  int n_err;
  int grants;

  int_ctrl dut (
    .clk        (clk),
    .CLR        (CLR),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .PC_cur     (PC_cur),
    .PC_EN      (PC_EN),
    .Branch     (Branch),
    .J          (J),
    .ERET       (ERET),
    .Int        (Int),
    .Iaddr      (Iaddr),
    .EPC        (EPC),
    .pending    (pending),
    .in_service (in_service),
    .depth      (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; grants = 0;
    CLR = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; PC_cur = '0;
    PC_EN = 1'b1; Branch = 1'b0; J = 1'b0; ERET = 1'b0;
    step(2);
    chk("rst_int",   32'(Int), 0);
    chk("rst_iaddr", Iaddr, 0);
    chk("rst_epc",   EPC, 0);
    chk("rst_pend",  32'(pending), 0);
    chk("rst_insv",  32'(in_service), 0);
    chk("rst_depth", 32'(depth), 0);
    CLR = 1'b0;
    step(2);

    // Reset mid-cycle with pending=011 held back by a zero mask.
    mask_wdata = 3'b000; mask_we = 1'b1;
    step();
    mask_we = 1'b0;
    irq = 3'b011;
    step(3);
    chk("t1_pend_pre", 32'(pending), 32'h3);
    chk("t1_int_msk",  32'(Int), 0);
    #2;
    CLR = 1'b1;
    #1;
    chk("t1_pend_clr",  32'(pending), 0);
    chk("t1_depth_clr", 32'(depth), 0);
    chk("t1_int_clr",   32'(Int), 0);
    chk("t1_epc_clr",   EPC, 0);
    irq = '0;
    @(posedge clk); #1;
    CLR = 1'b0;
    step(3);

    // Single request on line 1 (also proves the mask returned to 111).
    PC_cur = 32'h010; irq[1] = 1'b1;
    step();
    chk("t2_int_e1", 32'(Int), 0);
    step();
    chk("t2_int_e2",  32'(Int), 0);
    chk("t2_pend_e2", 32'(pending), 0);
    step();
    chk("t2_pend",  32'(pending), 32'h2);
    chk("t2_int",   32'(Int), 1);
    chk("t2_iaddr", Iaddr, 32'h240);
    step();
    chk("t2_int_off", 32'(Int), 0);
    chk("t2_depth",   32'(depth), 1);
    chk("t2_insv",    32'(in_service), 32'h2);
    chk("t2_epc",     EPC, 32'h010);
    chk("t2_pend_cl", 32'(pending), 0);
    ERET = 1'b1;
    #1;
    chk("t2_epc_eret", EPC, 32'h010);
    chk("t2_int_eret", 32'(Int), 0);
    step();
    ERET = 1'b0;
    chk("t2_depth_ret", 32'(depth), 0);
    chk("t2_insv_ret",  32'(in_service), 0);
    chk("t2_epc_ret",   EPC, 0);
    irq = '0;
    step(3);

    // Nesting: 0 then 2, with 1 arriving while 2 is in service.
    PC_cur = 32'h020; irq[0] = 1'b1;
    step(3);
    chk("t3_int0",   32'(Int), 1);
    chk("t3_iaddr0", Iaddr, 32'h200);
    step();
    chk("t3_depth1", 32'(depth), 1);
    chk("t3_insv1",  32'(in_service), 32'h1);
    chk("t3_epc1",   EPC, 32'h020);
    PC_cur = 32'h205; irq[2] = 1'b1;
    step(3);
    chk("t3_int2",   32'(Int), 1);
    chk("t3_iaddr2", Iaddr, 32'h280);
    step();
    chk("t3_depth2", 32'(depth), 2);
    chk("t3_epc2",   EPC, 32'h205);
    chk("t3_insv2",  32'(in_service), 32'h5);
    irq[1] = 1'b1;
    step(3);
    chk("t3_pend1",  32'(pending), 32'h2);
    chk("t3_blk1",   32'(Int), 0);
    step();
    chk("t3_blk1b",  32'(Int), 0);
    ERET = 1'b1;
    #1;
    chk("t3_epc_eret", EPC, 32'h205);
    chk("t3_int_eret", 32'(Int), 0);
    step();
    ERET = 1'b0; PC_cur = 32'h030;
    #1;
    chk("t3_depth_r1", 32'(depth), 1);
    chk("t3_epc_r1",   EPC, 32'h020);
    chk("t3_insv_r1",  32'(in_service), 32'h1);
    chk("t3_int1",     32'(Int), 1);
    chk("t3_iaddr1",   Iaddr, 32'h240);
    step();
    chk("t3_depth3", 32'(depth), 2);
    chk("t3_epc3",   EPC, 32'h030);
    chk("t3_insv3",  32'(in_service), 32'h3);
    ERET = 1'b1;
    step();
    chk("t3_depth_r2", 32'(depth), 1);
    chk("t3_epc_r2",   EPC, 32'h020);
    chk("t3_insv_r2",  32'(in_service), 32'h1);
    step();
    ERET = 1'b0;
    #1;
    chk("t3_depth_r3", 32'(depth), 0);
    chk("t3_insv_r3",  32'(in_service), 0);
    chk("t3_int_idle", 32'(Int), 0);
    irq = '0;
    step(3);

    // Redirect clash: Branch/J/ERET and a stall all defer the grant.
    irq[1] = 1'b1;
    step(2);
    Branch = 1'b1;
    #1;
    chk("t4_int_br0", 32'(Int), 0);
    step();
    chk("t4_pend",    32'(pending), 32'h2);
    chk("t4_int_br1", 32'(Int), 0);
    Branch = 1'b0; J = 1'b1;
    #1;
    chk("t4_int_j", 32'(Int), 0);
    J = 1'b0; ERET = 1'b1;
    #1;
    chk("t4_int_eret", 32'(Int), 0);
    ERET = 1'b0; Branch = 1'b1;
    step();
    chk("t4_int_br2",  32'(Int), 0);
    chk("t4_pend_br2", 32'(pending), 32'h2);
    Branch = 1'b0; PC_EN = 1'b0;
    #1;
    chk("t4_int_stall", 32'(Int), 0);
    step();
    PC_EN = 1'b1;
    #1;
    chk("t4_int",   32'(Int), 1);
    chk("t4_iaddr", Iaddr, 32'h240);
    step();
    chk("t4_depth",   32'(depth), 1);
    chk("t4_pend_cl", 32'(pending), 0);
    ERET = 1'b1;
    step();
    ERET = 1'b0;
    chk("t4_depth_ret", 32'(depth), 0);
    irq = '0;
    step(3);

    // Mask: line 1 disabled, request stays pending until re-enabled.
    mask_wdata = 3'b101; mask_we = 1'b1;
    step();
    mask_we = 1'b0; irq[1] = 1'b1;
    step(3);
    chk("t5_pend",  32'(pending), 32'h2);
    chk("t5_int_m", 32'(Int), 0);
    step();
    chk("t5_int_m2", 32'(Int), 0);
    chk("t5_insv_m", 32'(in_service), 0);
    mask_wdata = 3'b111; mask_we = 1'b1;
    #1;
    chk("t5_int_we", 32'(Int), 0);
    step();
    mask_we = 1'b0;
    #1;
    chk("t5_int",   32'(Int), 1);
    chk("t5_iaddr", Iaddr, 32'h240);
    step();
    chk("t5_depth", 32'(depth), 1);
    chk("t5_insv",  32'(in_service), 32'h2);
    ERET = 1'b1;
    step();
    ERET = 1'b0;
    chk("t5_depth_ret", 32'(depth), 0);
    irq = '0;
    step(3);

    // Level held high for 50 cycles yields exactly one grant.
    irq[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (Int) grants++;
    end
    chk("t6_grants", 32'(grants), 1);
    chk("t6_depth",  32'(depth), 1);
    chk("t6_insv",   32'(in_service), 32'h1);
    ERET = 1'b1;
    step();
    ERET = 1'b0;
    step(3);
    chk("t6_int_hold",  32'(Int), 0);
    chk("t6_pend_hold", 32'(pending), 0);
    chk("t6_depth_r",   32'(depth), 0);
    irq = '0;
    step(3);

    // ERET with an empty stack changes nothing.
    ERET = 1'b1;
    step();
    ERET = 1'b0;
    chk("t6_e0_depth", 32'(depth), 0);
    chk("t6_e0_insv",  32'(in_service), 0);
    chk("t6_e0_pend",  32'(pending), 0);
    chk("t6_e0_epc",   EPC, 0);

    // ERET and a fresh candidate in the same cycle: grant follows the return.
    PC_cur = 32'h040; irq[0] = 1'b1;
    step(3);
    chk("t6_sc_int0", 32'(Int), 1);
    step();
    chk("t6_sc_depth", 32'(depth), 1);
    irq[2] = 1'b1;
    step(3);
    ERET = 1'b1;
    #1;
    chk("t6_sc_pend", 32'(pending), 32'h4);
    chk("t6_sc_int_eret", 32'(Int), 0);
    step();
    ERET = 1'b0;
    #1;
    chk("t6_sc_depth_r", 32'(depth), 0);
    chk("t6_sc_int",     32'(Int), 1);
    chk("t6_sc_iaddr",   Iaddr, 32'h280);
    step();
    chk("t6_sc_depth2", 32'(depth), 1);
    chk("t6_sc_insv",   32'(in_service), 32'h4);
    chk("t6_sc_epc",    EPC, 32'h040);
    ERET = 1'b1;
    step();
    ERET = 1'b0;
    chk("t6_sc_depth3", 32'(depth), 0);
    irq = '0;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
